cmd_uart_wrapper: RTL and testbench

CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

---
 rtl/cmd_uart_wrapper.sv | 205 ++++++++++++++++++++
 tb/tb_cmd_uart_wrapper.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_wrapper.sv
// cmd_uart_wrapper: full-duplex UART front end for a remote command link.
// Two received bytes, high byte first, are assembled into a 16-bit command.
// A one-byte response is sent on request.
module cmd_uart_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  logic rx_meta, rx_sync;

  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_shift_en, byte_valid, frame_err;

  asm_state_t asm_state, asm_next;
  logic [7:0] high_byte;
  logic       hi_load, cmd_load;

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_data;
  logic          tx_start, tx_adv, tx_finish;

  // Two-flop synchronizer; presets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  // RX next state: mid-bit qualification of the start bit, then full-period sampling.
  always_comb begin
    rx_next     = rx_state;
    rx_shift_en = 1'b0;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_cnt == FULL_LAST) begin
          rx_shift_en = 1'b1;
          if (rx_bit == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == FULL_LAST) begin
          rx_next    = RX_IDLE;
          byte_valid = rx_sync;
          frame_err  = !rx_sync;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // RX state, baud counter (restarted on every state entry and bit), and LSB-first shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_next != rx_state || rx_shift_en)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START)
        rx_bit <= '0;
      else if (rx_shift_en)
        rx_bit <= rx_bit + 3'd1;
      if (rx_shift_en)
        rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  // Byte assembly: a framing error drops any pending high byte.
  always_comb begin
    asm_next = asm_state;
    hi_load  = 1'b0;
    cmd_load = 1'b0;
    if (frame_err) begin
      asm_next = ASM_HIGH;
    end else if (byte_valid) begin
      if (asm_state == ASM_HIGH) begin
        hi_load  = 1'b1;
        asm_next = ASM_LOW;
      end else begin
        cmd_load = 1'b1;
        asm_next = ASM_HIGH;
      end
    end
  end

  // Assembly state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asm_state <= ASM_HIGH;
    else        asm_state <= asm_next;
  end

  // Command register and ready flag; a completing command beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (hi_load)  high_byte <= rx_shift;
      if (cmd_load) cmd <= {high_byte, rx_shift};
      if (cmd_load)
        cmd_rdy <= 1'b1;
      else if (hi_load || clr_cmd_rdy)
        cmd_rdy <= 1'b0;
    end
  end

  // TX next state: accept a request only when idle, stop after ten bit periods.
  always_comb begin
    tx_next   = tx_state;
    tx_start  = 1'b0;
    tx_adv    = 1'b0;
    tx_finish = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (trmt) begin
          tx_next  = TX_XMIT;
          tx_start = 1'b1;
        end
      end
      TX_XMIT: begin
        if (tx_cnt == FULL_LAST) begin
          if (tx_bit == 4'd9) begin
            tx_next   = TX_IDLE;
            tx_finish = 1'b1;
          end else begin
            tx_adv = 1'b1;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX datapath: registered line output, latched byte shifted out LSB first behind the start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX      <= 1'b1;
      tx_done <= 1'b0;
      tx_data <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_start) begin
      tx_data <= {1'b1, resp};
      TX      <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_adv) begin
      TX      <= tx_data[0];
      tx_data <= {1'b1, tx_data[8:1]};
      tx_cnt  <= '0;
      tx_bit  <= tx_bit + 4'd1;
    end else if (tx_finish) begin
      TX      <= 1'b1;
      tx_done <= 1'b1;
      tx_cnt  <= '0;
    end else if (tx_state == TX_XMIT) begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb_cmd_uart_wrapper: directed bench with scoreboard queues for commands and TX bits.
module tb_cmd_uart_wrapper;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_done;
  logic [15:0] cmd;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] cmd_q[$];
  logic        tx_q[$];

  cmd_uart_wrapper #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, 16'(obs), 16'(exp));
  endtask

  // Serial frame from the remote: start, 8 data bits LSB first, stop, then idle gap.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 RX = 1'b0;
    repeat (BAUD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 RX = b[i];
      repeat (BAUD) @(posedge clk);
    end
    #1 RX = stop_bit;
    repeat (BAUD) @(posedge clk);
    #1 RX = 1'b1;
    repeat (2 * BAUD) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_rdy, then compares against the scoreboard head.
  task automatic checkCmd(input string tag);
    logic [15:0] exp;
    int n;
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 4 * BAUD) begin
      @(posedge clk); #1;
      n++;
    end
    checkBit({tag, "_rdy"}, cmd_rdy, 1'b1);
    exp = (cmd_q.size() != 0) ? cmd_q.pop_front() : 16'hxxxx;
    checkOutput(tag, cmd, exp);
  endtask

  // Requests a response byte and checks every TX bit mid-period; optional ignored re-request.
  task automatic sendResp(input logic [7:0] r, input bit poke);
    logic exp;
    int n;
    @(posedge clk); #1 resp = r; trmt = 1'b1;
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(r[i]);
    tx_q.push_back(1'b1);
    @(posedge clk); #1 trmt = 1'b0; resp = ~r;
    checkBit("tx_done_cleared", tx_done, 1'b0);
    repeat (BAUD / 2) @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      exp = tx_q.pop_front();
      checkBit($sformatf("tx_%02h_bit%0d", r, k), TX, exp);
      if (poke && k == 3) begin
        trmt = 1'b1; resp = 8'hFF;
        @(posedge clk); #1 trmt = 1'b0;
        repeat (BAUD - 1) @(posedge clk); #1;
      end else begin
        repeat (BAUD) @(posedge clk); #1;
      end
    end
    n = 0;
    while (tx_done !== 1'b1 && n < 2 * BAUD) begin
      @(posedge clk); #1;
      n++;
    end
    checkBit("tx_done_set", tx_done, 1'b1);
    checkBit("tx_idle_high", TX, 1'b1);
  endtask

  // Directed sequence.
  initial begin
    $display("[TB] start, BAUD_DIV=%0d", BAUD);
    repeat (3) @(posedge clk); #1;
    checkBit("rst_TX", TX, 1'b1);
    checkOutput("rst_cmd", cmd, 16'h0000);
    checkBit("rst_cmd_rdy", cmd_rdy, 1'b0);
    checkBit("rst_tx_done", tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (2 * BAUD) @(posedge clk); #1;

    // Basic command, partial command leaves cmd untouched.
    cmd_q.push_back(16'h7020);
    applyStimulus(8'h70, 1'b1);
    checkBit("partial_rdy", cmd_rdy, 1'b0);
    checkOutput("partial_cmd", cmd, 16'h0000);
    applyStimulus(8'h20, 1'b1);
    checkCmd("cmd_7020");

    // High byte deasserts cmd_rdy and keeps cmd.
    cmd_q.push_back(16'h1234);
    applyStimulus(8'h12, 1'b1);
    checkBit("hi_clears_rdy", cmd_rdy, 1'b0);
    checkOutput("hi_keeps_cmd", cmd, 16'h7020);
    applyStimulus(8'h34, 1'b1);
    checkCmd("cmd_1234");

    // Consumer acknowledge.
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    checkBit("clr_rdy", cmd_rdy, 1'b0);
    checkOutput("clr_keeps_cmd", cmd, 16'h1234);

    // Framing error discards the byte and resynchronises assembly.
    applyStimulus(8'h70, 1'b0);
    checkBit("ferr_rdy", cmd_rdy, 1'b0);
    checkOutput("ferr_cmd", cmd, 16'h1234);
    cmd_q.push_back(16'h2000);
    applyStimulus(8'h20, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkCmd("cmd_2000");

    // Short start-bit glitch is rejected.
    @(posedge clk); #1 RX = 1'b0;
    repeat (BAUD / 4) @(posedge clk); #1 RX = 1'b1;
    repeat (2 * BAUD) @(posedge clk); #1;
    checkBit("glitch_rdy", cmd_rdy, 1'b1);
    checkOutput("glitch_cmd", cmd, 16'h2000);
    cmd_q.push_back(16'h1234);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    checkCmd("cmd_after_glitch");

    // Response 0x5A with an ignored mid-frame request.
    sendResp(8'h5A, 1'b1);

    // Full duplex: command received while a response goes out.
    cmd_q.push_back(16'hC33C);
    fork
      begin
        applyStimulus(8'hC3, 1'b1);
        applyStimulus(8'h3C, 1'b1);
      end
      sendResp(8'hA5, 1'b0);
    join
    checkCmd("cmd_duplex");

    // Reset in the middle of the data bits of a high byte.
    @(posedge clk); #1 RX = 1'b0;
    repeat (BAUD) @(posedge clk); #1 RX = 1'b1;
    repeat (BAUD) @(posedge clk); #1 RX = 1'b0;
    repeat (BAUD / 2) @(posedge clk); #1 rst_n = 1'b0; RX = 1'b1;
    #1;
    checkBit("async_rst_TX", TX, 1'b1);
    checkOutput("async_rst_cmd", cmd, 16'h0000);
    checkBit("async_rst_rdy", cmd_rdy, 1'b0);
    checkBit("async_rst_tx_done", tx_done, 1'b0);
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (2 * BAUD) @(posedge clk); #1;
    cmd_q.push_back(16'hABCD);
    applyStimulus(8'hAB, 1'b1);
    checkBit("post_rst_TX_a", TX, 1'b1);
    applyStimulus(8'hCD, 1'b1);
    checkBit("post_rst_TX_b", TX, 1'b1);
    checkBit("post_rst_tx_done", tx_done, 1'b0);
    checkCmd("cmd_abcd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guards against a hung sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
